// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN accelerator front end.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } enc_state_t;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load and step enable.
module lfsr16
    import snn_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        en_i,
    output logic [15:0] state_o
);

    // A zero seed would lock the register at zero forever.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = SEED_EFF;
        end else if (en_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED_EFF;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/image_spike_encoder.sv
// Rate-coding pixel encoder: snapshots an image and streams LFSR-thresholded
// pixel spikes as (address, timestep) events over a valid/ready interface.
module image_spike_encoder
    import snn_pkg::*;
#(
    parameter int unsigned IMAGE_SIZE      = 256,
    parameter int unsigned IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int unsigned PIXEL_MAX_VALUE = 255,
    parameter int unsigned PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
    parameter int unsigned NUM_TIMESTEPS   = 32,
    parameter int unsigned TS_BITS         = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                                       ACLK,
    input  logic                                       ARESETN,
    input  logic [0:IMAGE_SIZE-1][PIXEL_BITS-1:0]      IMAGE,
    input  logic                                       NEW_IMAGE,
    output logic                                       SPIKE_VALID,
    input  logic                                       SPIKE_READY,
    output logic [IMAGE_SIZE_BITS-1:0]                 SPIKE_ADDR,
    output logic [TS_BITS-1:0]                         SPIKE_TS,
    output logic                                       BUSY,
    output logic                                       DONE,
    output logic                                       OVERRUN
);

    localparam logic [IMAGE_SIZE_BITS-1:0] PIX_LAST = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
    localparam logic [TS_BITS-1:0]         TS_LAST  = TS_BITS'(NUM_TIMESTEPS - 1);

    enc_state_t                            state_q;
    logic                                  nimg_q;
    logic [IMAGE_SIZE_BITS-1:0]            pix_idx_q;
    logic [TS_BITS-1:0]                    ts_q;
    logic [0:IMAGE_SIZE-1][PIXEL_BITS-1:0] img_buf_q;
    logic                                  valid_q;
    logic [IMAGE_SIZE_BITS-1:0]            addr_q;
    logic [TS_BITS-1:0]                    spike_ts_q;
    logic                                  busy_q;
    logic                                  done_q;
    logic                                  overrun_q;

    logic        start;
    logic        slot_free;
    logic        eval;
    logic        spike;
    logic        valid_d;
    logic        last_pix;
    logic        last_ts;
    logic        lfsr_load;
    logic [15:0] lfsr_state;

    assign start     = NEW_IMAGE & ~nimg_q;
    assign slot_free = ~valid_q | SPIKE_READY;
    assign eval      = (state_q == RUN) & slot_free;
    assign spike     = eval & (img_buf_q[pix_idx_q] > PIXEL_BITS'(lfsr_state[7:0]));
    assign valid_d   = spike | (valid_q & ~SPIKE_READY);
    assign last_pix  = (pix_idx_q == PIX_LAST);
    assign last_ts   = (ts_q == TS_LAST);
    assign lfsr_load = (state_q == IDLE) & start;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .load_i  (lfsr_load),
        .en_i    (eval),
        .state_o (lfsr_state)
    );

    // Snapshot buffer; contents are irrelevant outside a run, so no reset.
    always_ff @(posedge ACLK) begin
        if (state_q == LOAD) begin
            img_buf_q <= IMAGE;
        end
    end

    // Control FSM, scan counters and the output event register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            nimg_q     <= 1'b0;
            pix_idx_q  <= '0;
            ts_q       <= '0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            spike_ts_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            nimg_q  <= NEW_IMAGE;
            valid_q <= valid_d;
            done_q  <= 1'b0;
            if (spike) begin
                addr_q     <= pix_idx_q;
                spike_ts_q <= ts_q;
            end
            if (start && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= LOAD;
                        busy_q    <= 1'b1;
                        overrun_q <= 1'b0;
                        pix_idx_q <= '0;
                        ts_q      <= '0;
                    end
                end
                LOAD: begin
                    state_q <= RUN;
                end
                RUN: begin
                    if (eval) begin
                        if (last_pix) begin
                            pix_idx_q <= '0;
                            ts_q      <= ts_q + TS_BITS'(1);
                        end else begin
                            pix_idx_q <= pix_idx_q + IMAGE_SIZE_BITS'(1);
                        end
                        if (last_pix && last_ts) begin
                            state_q <= DRAIN;
                            done_q  <= ~valid_d;
                        end
                    end
                end
                DRAIN: begin
                    // DONE is high exactly while draining with an empty output register.
                    if (!valid_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        done_q <= ~valid_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign SPIKE_VALID = valid_q;
    assign SPIKE_ADDR  = addr_q;
    assign SPIKE_TS    = spike_ts_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_image_spike_encoder.sv
// Bench for image_spike_encoder: golden LFSR model feeds an event scoreboard,
// table-driven runs plus hand-written overrun and mid-run reset sequences.
module tb_image_spike_encoder;

    localparam int unsigned N_PIX = 256;
    localparam int unsigned NT    = 4;
    localparam int unsigned N_EV  = N_PIX * NT;

    logic                     ACLK = 1'b0;
    logic                     ARESETN;
    logic [0:N_PIX-1][7:0]    IMAGE;
    logic                     NEW_IMAGE;
    logic                     SPIKE_VALID;
    logic                     SPIKE_READY;
    logic [7:0]               SPIKE_ADDR;
    logic [1:0]               SPIKE_TS;
    logic                     BUSY;
    logic                     DONE;
    logic                     OVERRUN;

    image_spike_encoder #(
        .NUM_TIMESTEPS (NT)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .IMAGE       (IMAGE),
        .NEW_IMAGE   (NEW_IMAGE),
        .SPIKE_VALID (SPIKE_VALID),
        .SPIKE_READY (SPIKE_READY),
        .SPIKE_ADDR  (SPIKE_ADDR),
        .SPIKE_TS    (SPIKE_TS),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .OVERRUN     (OVERRUN)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [7:0] addr;
        logic [1:0] ts;
    } ev_t;

    typedef struct {
        int pattern;      // 0 all-zero, 1 all-255, 2 test vector
        int ready_pct;
        int overrun_at;   // cycle of a second NEW_IMAGE edge, 0 = none
        int exp_events;   // -1 = use model count only
    } vec_t;

    int tests = 0;
    int fails = 0;

    ev_t        exp_q[$];
    logic [7:0] test_img [N_PIX];
    logic [7:0] cur_img  [N_PIX];
    int         model_count;
    bit         model_last_spike;

    int         cyc;
    int         done_cyc;
    int         first_valid_cyc;
    int         n_ev;
    logic       prev_valid;
    logic       prev_ready;
    logic [7:0] prev_addr;
    logic [1:0] prev_ts;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Golden stream for cur_img, starting from the default seed.
    task automatic build_model();
        logic [15:0] l;
        bit          sp;
        ev_t         e;
        exp_q.delete();
        model_count = 0;
        l = 16'hACE1;
        for (int t = 0; t < int'(NT); t++) begin
            for (int p = 0; p < int'(N_PIX); p++) begin
                sp = (cur_img[p] > l[7:0]);
                if (sp) begin
                    e.addr = 8'(p);
                    e.ts   = 2'(t);
                    exp_q.push_back(e);
                    model_count++;
                end
                model_last_spike = sp;
                l = model_step(l);
            end
        end
    endtask

    task automatic load_pattern(input int pattern);
        for (int p = 0; p < int'(N_PIX); p++) begin
            case (pattern)
                0:       cur_img[p] = 8'd0;
                1:       cur_img[p] = 8'd255;
                default: cur_img[p] = test_img[p];
            endcase
            IMAGE[p] = cur_img[p];
        end
    endtask

    // Observe the current cycle, score any transfer, then advance one clock.
    task automatic sample_and_step(input int pct);
        ev_t e;
        if (prev_valid && !prev_ready) begin
            check("hold_valid", 64'(SPIKE_VALID), 64'(1'b1));
            check("hold_addr",  64'(SPIKE_ADDR),  64'(prev_addr));
            check("hold_ts",    64'(SPIKE_TS),    64'(prev_ts));
        end
        if (SPIKE_VALID && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (SPIKE_VALID && SPIKE_READY) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_event: got addr %0d ts %0d, expected no event (cycle %0d)",
                         SPIKE_ADDR, SPIKE_TS, cyc);
            end else begin
                e = exp_q.pop_front();
                check("ev_addr", 64'(SPIKE_ADDR), 64'(e.addr));
                check("ev_ts",   64'(SPIKE_TS),   64'(e.ts));
            end
            n_ev++;
        end
        if (DONE && done_cyc < 0) done_cyc = cyc;
        prev_valid = SPIKE_VALID;
        prev_ready = SPIKE_READY;
        prev_addr  = SPIKE_ADDR;
        prev_ts    = SPIKE_TS;
        @(posedge ACLK);
        #1;
        cyc++;
        SPIKE_READY = ($urandom_range(99) < pct);
    endtask

    task automatic begin_run(input int pattern, input int pct);
        load_pattern(pattern);
        build_model();
        SPIKE_READY = ($urandom_range(99) < pct);
        NEW_IMAGE   = 1'b1;
        @(posedge ACLK);
        #1;
        cyc             = 1;
        done_cyc        = -1;
        first_valid_cyc = -1;
        n_ev            = 0;
        prev_valid      = 1'b0;
        prev_ready      = 1'b1;
        check("busy_cycle1",  64'(BUSY),        64'(1'b1));
        check("valid_cycle1", 64'(SPIKE_VALID), 64'(1'b0));
    endtask

    task automatic run_image(input vec_t v);
        begin_run(v.pattern, v.ready_pct);
        while (done_cyc < 0 && cyc < int'(N_EV) * 6 + 200) begin
            if (cyc == 2) begin
                check("overrun_cleared", 64'(OVERRUN), 64'(1'b0));
                for (int p = 0; p < int'(N_PIX); p++) IMAGE[p] = ~cur_img[p];
            end
            if (cyc == 50) NEW_IMAGE = 1'b0;
            if (v.overrun_at > 0 && cyc == v.overrun_at) NEW_IMAGE = 1'b1;
            if (v.overrun_at > 0 && cyc == v.overrun_at + 10) NEW_IMAGE = 1'b0;
            sample_and_step(v.ready_pct);
        end
        check("done_seen", 64'(done_cyc >= 0), 64'(1'b1));
        check("done_one_cycle",   64'(DONE), 64'(1'b0));
        check("busy_after_done",  64'(BUSY), 64'(1'b0));
        check("events_left",      64'(exp_q.size()), 64'(0));
        check("event_count",      64'(n_ev), 64'(model_count));
        if (v.exp_events >= 0) check("event_count_exact", 64'(n_ev), 64'(v.exp_events));
        if (v.ready_pct == 100)
            check("done_cycle", 64'(done_cyc), 64'(2 + int'(N_EV) + (model_last_spike ? 1 : 0)));
        check("overrun_flag", 64'(OVERRUN), 64'(v.overrun_at > 0));
        if (v.pattern == 0) check("zero_never_valid", 64'(first_valid_cyc), 64'(-1));
        if (v.pattern == 1) check("first_valid_cycle", 64'(first_valid_cyc), 64'(3));
        SPIKE_READY = 1'b1;
        NEW_IMAGE   = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},   64'(SPIKE_VALID), 64'(0));
        check({tag, "_addr"},    64'(SPIKE_ADDR),  64'(0));
        check({tag, "_ts"},      64'(SPIKE_TS),    64'(0));
        check({tag, "_busy"},    64'(BUSY),        64'(0));
        check({tag, "_done"},    64'(DONE),        64'(0));
        check({tag, "_overrun"}, 64'(OVERRUN),     64'(0));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{pattern: 0, ready_pct: 100, overrun_at: 0,   exp_events: 0};
        vecs[1] = '{pattern: 1, ready_pct: 100, overrun_at: 0,   exp_events: -1};
        vecs[2] = '{pattern: 2, ready_pct: 100, overrun_at: 0,   exp_events: -1};
        vecs[3] = '{pattern: 2, ready_pct: 30,  overrun_at: 0,   exp_events: -1};
        vecs[4] = '{pattern: 2, ready_pct: 100, overrun_at: 100, exp_events: -1};
        vecs[5] = '{pattern: 2, ready_pct: 100, overrun_at: 0,   exp_events: -1};

        for (int p = 0; p < int'(N_PIX); p++) test_img[p] = 8'($urandom_range(255));
        test_img[0] = 8'd0;

        cyc         = 0;
        ARESETN     = 1'b0;
        NEW_IMAGE   = 1'b0;
        SPIKE_READY = 1'b1;
        IMAGE       = '0;
        repeat (3) @(posedge ACLK);
        #1;
        check_reset_outputs("reset");
        #3 ARESETN = 1'b1;
        @(posedge ACLK);
        #1;

        for (int i = 0; i < 6; i++) run_image(vecs[i]);

        // Reset while an event is stalled on the output, then restart cleanly.
        begin_run(2, 0);
        NEW_IMAGE = 1'b0;
        while (!(SPIKE_VALID && cyc >= 20) && cyc < 400) sample_and_step(0);
        check("valid_before_reset", 64'(SPIKE_VALID), 64'(1'b1));
        #2 ARESETN = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        @(posedge ACLK);
        #3 ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        run_image(vecs[2]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/image_spike_encoder.md
# image_spike_encoder

Rate-coding front end of the SNN accelerator, directly downstream of the AXI slave interface. On a rising edge of NEW_IMAGE it snapshots the 256-pixel image and emits pixel spikes for NUM_TIMESTEPS timesteps. In each timestep it scans pixels 0..IMAGE_SIZE-1 in order. A pixel spikes when its value exceeds a pseudo-random byte from an LFSR. Spikes leave as address events on a valid/ready stream into the network core.

## Interface
Parameters:
- IMAGE_SIZE, 256: number of pixels per image.
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE): pixel address width.
- PIXEL_MAX_VALUE, 255: maximum pixel value.
- PIXEL_BITS, $clog2(PIXEL_MAX_VALUE): pixel width (8).
- NUM_TIMESTEPS, 32: timesteps per image, must be ≥1.
- TS_BITS, $clog2(NUM_TIMESTEPS): timestep index width, minimum 1.
- LFSR_SEED, 16'hACE1: LFSR reseed value; a value of 0 is replaced by 16'hACE1.

Ports:
- ACLK, in, 1: clock.
- ARESETN, in, 1: reset, asynchronous, active-low.
- IMAGE, in, PIXEL_BITS × [0:IMAGE_SIZE-1]: pixel array from the AXI interface.
- NEW_IMAGE, in, 1: start request, rising-edge sensitive.
- SPIKE_VALID, out, 1: spike event present.
- SPIKE_READY, in, 1: consumer accepts the event.
- SPIKE_ADDR, out, IMAGE_SIZE_BITS: address of the spiking pixel.
- SPIKE_TS, out, TS_BITS: timestep of the event.
- BUSY, out, 1: encoding in progress (any state except IDLE).
- DONE, out, 1: one-cycle pulse when the image is fully encoded and drained.
- OVERRUN, out, 1: sticky flag; a start request arrived while BUSY.

## Operation
- Edge detect: nimg_q registers NEW_IMAGE. start = NEW_IMAGE & ~nimg_q.
- FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE → LOAD on start.
  - Clears OVERRUN.
  - Reseeds LFSR.
  - Sets pix_idx = 0 and ts = 0.
- LOAD, one cycle:
  - Copies IMAGE into the internal buffer img_buf.
  - Later changes on IMAGE do not affect the run.
  - Always goes to RUN.
- RUN: evaluates pixel pix_idx when the output register is empty or is being accepted in the same cycle (slot_free).
  - spike = img_buf[pix_idx] > lfsr[7:0] (unsigned compare).
  - On spike, loads the output register with {pix_idx, ts} and sets SPIKE_VALID.
  - The LFSR advances once per evaluated pixel only, never on stall cycles.
  - pix_idx increments. At IMAGE_SIZE-1 it wraps to 0 and ts increments.
  - After evaluating pixel IMAGE_SIZE-1 of timestep NUM_TIMESTEPS-1, goes to DRAIN.
- DRAIN: waits until the output register is empty. In that cycle DONE=1 and the FSM goes to IDLE.
- LFSR: 16-bit Galois, taps 16'hB400, shifts right. Shift rule: lsb=lfsr[0]; lfsr = (lfsr>>1) ^ (lsb ? 16'hB400 : 0).
- Resulting pixel behaviour: pixel value 0 never spikes; 255 spikes unless lfsr[7:0]==255.
- start while BUSY: the request is ignored, OVERRUN is set to 1, and the current run continues.
- Handshake:
  - Once SPIKE_VALID=1, SPIKE_VALID, SPIKE_ADDR and SPIKE_TS hold until the cycle with SPIKE_READY=1.
  - The transfer happens when SPIKE_VALID & SPIKE_READY at the rising edge.
  - A new event may load in the same cycle as the transfer, so there is no bubble.
- Reset, including mid-run:
  - FSM goes to IDLE and the LFSR is set to the seed.
  - pix_idx, ts, nimg_q and the output register are cleared.
  - Any in-flight event is dropped.
  - img_buf contents are don't-care.

## Timing
- Reset values: SPIKE_VALID=0, SPIKE_ADDR=0, SPIKE_TS=0, BUSY=0, DONE=0, OVERRUN=0.
- Cycle numbering: cycle 0 is the edge where start is sampled.
  - Cycle 1: LOAD.
  - Cycle 2: pixel 0 evaluated.
  - Earliest SPIKE_VALID: cycle 3.
- Throughput: one pixel per cycle while SPIKE_READY=1. Stalls occur only when a spike is pending and SPIKE_READY=0.
- With no backpressure:
  - Last evaluation is in cycle 1+IMAGE_SIZE·NUM_TIMESTEPS.
  - DONE is high in cycle 2+IMAGE_SIZE·NUM_TIMESTEPS if the final event was accepted; otherwise DONE is delayed by the stall.
- BUSY rises in cycle 1 and falls the cycle after DONE.

## Structure
- Shared package snn_pkg holds:
  - the state enum typedef enc_state_t {IDLE, LOAD, RUN, DRAIN};
  - constant LFSR_TAPS = 16'hB400;
  - constant LFSR_DEFAULT_SEED = 16'hACE1.
- Sub-module lfsr16: seed load, enable, 16-bit state out.
- The rest is a single module: FSM, counters, img_buf, and the output register.

## Test plan
- All-zero image, NUM_TIMESTEPS=4, SPIKE_READY=1 → no SPIKE_VALID; DONE pulses at cycle 2+1024; BUSY low after.
- All-255 image, NUM_TIMESTEPS=1 → spikes in address order; count equals the golden-model count of lfsr[7:0]≠255 over 256 steps; SPIKE_TS=0 throughout.
- Full image from the AXI test vector, NUM_TIMESTEPS=32 → the spike stream (addr, ts) matches a software model bit-exactly; pixel 0 addresses never appear.
- SPIKE_READY random at 30% duty → identical stream to the READY=1 run; signals hold stable while stalled; no event lost or duplicated.
- Second NEW_IMAGE rising edge at cycle 100 → OVERRUN=1; stream unchanged; next start after DONE clears OVERRUN.
- ARESETN low mid-run while SPIKE_VALID=1 → all outputs at reset values immediately; a fresh start reproduces the stream from its first event.
